frame_former_controller: RTL and testbench
==========================================

# frame_former_controller

Sequences the frame-former buffer into complete Ethernet-style frames on a 64-bit AXI-Stream master. Waits for buffered payload, emits two configured header words, pops exactly PAYLOAD_WORDS words from the buffer, zero-pads up to a minimum frame length, asserts tlast, then enforces an inter-frame gap. Sits between the subordinate buffer (driving its pop/ready input) and the MAC/TX stream.

## Interface
- PAYLOAD_WORDS, 8: 64-bit payload words popped per frame, range 1–255.
- MIN_FRAME_WORDS, 8: minimum total beats per frame, headers included; zero-pad beats fill the shortfall.
- START_THRESHOLD, 1: buffer occupancy required to leave IDLE, range 1–64.
- GAP_CYCLES, 3: idle cycles after tlast beat, range 0–255.
- CNT_WIDTH, 7: width of buf_count; matches buffer tail width.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cfg_dst_mac  in  48  destination address; sampled at frame start.
- cfg_src_mac  in  48  source address; sampled at frame start.
- cfg_ethertype  in  16  type field; sampled at frame start.
- enable  in  1  when low, no new frame starts; an in-flight frame always completes.
- buf_data  in  64  buffer head word, valid when buf_empty low.
- buf_empty  in  1  buffer empty.
- buf_count  in  CNT_WIDTH  buffer occupancy.
- buf_pop  out  1  pops buffer head this cycle; feeds the buffer's ready input.
- M_AXIS_tdata  out  64  frame beat.
- M_AXIS_tkeep  out  8  always 8'hFF.
- M_AXIS_tvalid  out  1  beat valid.
- M_AXIS_tlast  out  1  final beat of frame.
- M_AXIS_tready  in  1  downstream ready.
- busy  out  1  state not IDLE.
- frames_sent  out  16  completed frame count, wraps at 16'hFFFF→0.
- underrun_stalls  out  16  cycles spent in PAYLOAD with buf_empty high, saturating at 16'hFFFF.

## Operation
- States: IDLE, HDR0, HDR1, PAYLOAD, PAD, GAP.
- IDLE: exit to HDR0 when enable & buf_count >= START_THRESHOLD. Same edge latches cfg_* into shadow registers and clears beat counter.
- HDR0: tdata = {dst[47:0], src[47:32]}, tvalid=1. Advance on tready.
- HDR1: tdata = {src[31:0], ethertype[15:0], 16'h0000}, tvalid=1. Advance to PAYLOAD on tready.
- PAYLOAD: tdata = buf_data (combinational pass-through), tvalid = !buf_empty, buf_pop = tvalid & tready. Payload counter increments on each pop. After pop PAYLOAD_WORDS: to PAD if 2+PAYLOAD_WORDS < MIN_FRAME_WORDS, else GAP.
- PAD: tdata = 64'h0, tvalid=1, one beat per handshake until total beats = MIN_FRAME_WORDS.
- tlast high on the final beat only (last payload beat or last pad beat), qualified with tvalid.
- GAP: tvalid=0 for GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 goes straight to IDLE next cycle.
- frames_sent increments on handshake of tlast beat.
- buf_pop never asserted outside PAYLOAD, never when buf_empty high.
- Header words and pad beats hold tdata stable while tvalid & !tready.
- cfg_* changes during a frame do not affect that frame.

## Timing
- Reset values: state IDLE, buf_pop 0, tvalid 0, tlast 0, tdata 0, busy 0, frames_sent 0, underrun_stalls 0.
- Start latency: condition true at edge N → HDR0 beat valid from cycle N+1.
- Zero-bubble throughput: with tready=1 and buffer non-empty, one beat per cycle from HDR0 to tlast.
- Frame length = max(2+PAYLOAD_WORDS, MIN_FRAME_WORDS) beats; defaults give 10 beats.
- Back-to-back frames separated by GAP_CYCLES+1 idle cycles (GAP + IDLE evaluation).
- Underrun: buffer empty mid-payload → tvalid drops, frame held open indefinitely, no pad substitution; underrun_stalls counts each such cycle.
- Backpressure: tready low freezes state, counters and tdata; buf_pop low.
- ARESET mid-frame: next edge returns to IDLE with all outputs at reset values; partial frame is abandoned without tlast (downstream MAC discards it); buffer contents untouched.

## Test plan
- Defaults, buffer preloaded with 8 words 0x11..0x88, tready=1 → 10 consecutive beats: HDR0, HDR1, 0x11..0x88, tlast on 0x88; 8 pops; frames_sent=1.
- PAYLOAD_WORDS=2, MIN_FRAME_WORDS=8, 2 words buffered → 2 headers, 2 payload, 4 zero pad beats, tlast on 8th beat; exactly 2 pops.
- tready toggled 1/0 every cycle through a default frame → each beat held stable while stalled; no duplicated or dropped words; 10 handshakes total.
- Buffer supplies 3 words, 5-cycle gap, then 5 words → tvalid low 5 cycles in PAYLOAD, underrun_stalls=5, frame completes correctly.
- ARESET pulsed on payload beat 4 → next cycle tvalid=0, busy=0, frames_sent=0; remaining 4 words stay in buffer; next frame starts cleanly with HDR0.
- enable=0 with 16 words buffered → no start; raise enable → two back-to-back frames with GAP_CYCLES=3 showing 4 idle cycles between tlast and next HDR0.

Source files
------------

// File: rtl/frame_former_controller.sv
// frame_former_controller
// Drains the frame-former buffer into framed beats on a 64-bit AXI-Stream master.
// Each frame carries two header words built from the cfg_* values captured at the
// start of the frame. PAYLOAD_WORDS buffer words follow. Zero pad beats are added
// when the frame would otherwise be shorter than MIN_FRAME_WORDS. After the beat
// that carries tlast, GAP_CYCLES idle cycles are enforced.
//
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   cfg_dst_mac/src_mac/     header fields, captured when a frame starts
//     cfg_ethertype
//   enable                   permits new frames; an in-flight frame always completes
//   buf_data/empty/count     head word, empty flag and occupancy of the buffer
//   buf_pop                  pops the buffer head (buffer ready input)
//   M_AXIS_*                 64-bit stream master (tkeep is always all-ones)
//   busy                     controller is not idle
//   frames_sent              completed frames, wrapping
//   underrun_stalls          PAYLOAD cycles with an empty buffer, saturating
module frame_former_controller #(
  parameter int unsigned PAYLOAD_WORDS   = 8,
  parameter int unsigned MIN_FRAME_WORDS = 8,
  parameter int unsigned START_THRESHOLD = 1,
  parameter int unsigned GAP_CYCLES      = 3,
  parameter int unsigned CNT_WIDTH       = 7
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [47:0]          cfg_dst_mac,
  input  logic [47:0]          cfg_src_mac,
  input  logic [15:0]          cfg_ethertype,
  input  logic                 enable,
  input  logic [63:0]          buf_data,
  input  logic                 buf_empty,
  input  logic [CNT_WIDTH-1:0] buf_count,
  output logic                 buf_pop,
  output logic [63:0]          M_AXIS_tdata,
  output logic [7:0]           M_AXIS_tkeep,
  output logic                 M_AXIS_tvalid,
  output logic                 M_AXIS_tlast,
  input  logic                 M_AXIS_tready,
  output logic                 busy,
  output logic [15:0]          frames_sent,
  output logic [15:0]          underrun_stalls
);

  localparam int unsigned PAD_BEATS =
    (2 + PAYLOAD_WORDS < MIN_FRAME_WORDS) ? (MIN_FRAME_WORDS - 2 - PAYLOAD_WORDS) : 0;
  localparam bit                   HAS_PAD   = (PAD_BEATS != 0);
  localparam logic [15:0]          PAY_LAST  = 16'(PAYLOAD_WORDS - 1);
  localparam logic [15:0]          PAD_LAST  = 16'(PAD_BEATS - 1);
  localparam logic [7:0]           GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] START_LVL = CNT_WIDTH'(START_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_PAD,
    S_GAP
  } state_e;

  // A zero-length gap returns straight to IDLE after the final beat.
  localparam state_e AFTER_LAST = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [47:0] dst_q, src_q;
  logic [15:0] type_q;
  logic [15:0] frames_q;
  logic [15:0] stalls_q;

  logic        tvalid_w, tlast_w, pop_w;
  logic [63:0] tdata_w;

  // State register and frame bookkeeping
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      type_q   <= '0;
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      if (state_q == S_IDLE && state_d == S_HDR0) begin
        dst_q  <= cfg_dst_mac;
        src_q  <= cfg_src_mac;
        type_q <= cfg_ethertype;
      end
      if (tvalid_w && M_AXIS_tready && tlast_w) begin
        frames_q <= frames_q + 16'd1;
      end
      if (state_q == S_PAYLOAD && buf_empty && stalls_q != '1) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (enable && buf_count >= START_LVL) begin
          state_d = S_HDR0;
          cnt_d   = '0;
        end
      end
      S_HDR0: begin
        if (M_AXIS_tready) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (M_AXIS_tready) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
        end
      end
      S_PAYLOAD: begin
        if (pop_w) begin
          if (cnt_q == PAY_LAST) begin
            cnt_d   = '0;
            gap_d   = '0;
            state_d = HAS_PAD ? S_PAD : AFTER_LAST;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_PAD: begin
        if (M_AXIS_tready) begin
          if (cnt_q == PAD_LAST) begin
            gap_d   = '0;
            state_d = AFTER_LAST;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tdata_w  = '0;
    tvalid_w = 1'b0;
    tlast_w  = 1'b0;
    pop_w    = 1'b0;
    case (state_q)
      S_HDR0: begin
        tdata_w  = {dst_q, src_q[47:32]};
        tvalid_w = 1'b1;
      end
      S_HDR1: begin
        tdata_w  = {src_q[31:0], type_q, 16'h0000};
        tvalid_w = 1'b1;
      end
      S_PAYLOAD: begin
        tdata_w  = buf_data;
        tvalid_w = !buf_empty;
        tlast_w  = !HAS_PAD && (cnt_q == PAY_LAST) && !buf_empty;
        pop_w    = !buf_empty && M_AXIS_tready;
      end
      S_PAD: begin
        tvalid_w = 1'b1;
        tlast_w  = (cnt_q == PAD_LAST);
      end
      default: ;
    endcase
    // Suppress the handshake in the reset cycle itself so an abandoned frame
    // neither consumes a buffer word nor hands a beat downstream at that edge.
    if (ARESET) begin
      tvalid_w = 1'b0;
      tlast_w  = 1'b0;
      pop_w    = 1'b0;
    end
  end

  assign buf_pop         = pop_w;
  assign M_AXIS_tdata    = tdata_w;
  assign M_AXIS_tvalid   = tvalid_w;
  assign M_AXIS_tlast    = tlast_w;
  assign M_AXIS_tkeep    = 8'hFF;
  assign busy            = (state_q != S_IDLE);
  assign frames_sent     = frames_q;
  assign underrun_stalls = stalls_q;

endmodule

// File: tb/tb_frame_former_controller.sv
// Testbench for frame_former_controller.
// Two instances are used. Instance A has the defaults (8 payload words, minimum 8 beats,
// gap 3). Instance B has 2 payload words, minimum 8 beats and gap 0.
// The reference model is stream-level. It keeps the buffer contents in a queue, keeps the
// position inside the current frame, and tracks the header fields captured at frame start.
// The expected value of every beat follows from that position.
module tb_frame_former_controller;

  localparam int unsigned CW = 7;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          arst   [2];
  logic [47:0]   dst    [2];
  logic [47:0]   src    [2];
  logic [15:0]   et     [2];
  logic          en     [2];
  logic [63:0]   bdata  [2];
  logic          bempty [2];
  logic [CW-1:0] bcount [2];
  logic          pop    [2];
  logic [63:0]   td     [2];
  logic [7:0]    tk     [2];
  logic          tv     [2];
  logic          tl     [2];
  logic          tr     [2];
  logic          bsy    [2];
  logic [15:0]   fs     [2];
  logic [15:0]   us     [2];

  frame_former_controller #(
    .PAYLOAD_WORDS(8), .MIN_FRAME_WORDS(8), .START_THRESHOLD(1), .GAP_CYCLES(3), .CNT_WIDTH(CW)
  ) u_a (
    .ACLK(ACLK), .ARESET(arst[0]), .cfg_dst_mac(dst[0]), .cfg_src_mac(src[0]),
    .cfg_ethertype(et[0]), .enable(en[0]), .buf_data(bdata[0]), .buf_empty(bempty[0]),
    .buf_count(bcount[0]), .buf_pop(pop[0]), .M_AXIS_tdata(td[0]), .M_AXIS_tkeep(tk[0]),
    .M_AXIS_tvalid(tv[0]), .M_AXIS_tlast(tl[0]), .M_AXIS_tready(tr[0]), .busy(bsy[0]),
    .frames_sent(fs[0]), .underrun_stalls(us[0])
  );

  frame_former_controller #(
    .PAYLOAD_WORDS(2), .MIN_FRAME_WORDS(8), .START_THRESHOLD(1), .GAP_CYCLES(0), .CNT_WIDTH(CW)
  ) u_b (
    .ACLK(ACLK), .ARESET(arst[1]), .cfg_dst_mac(dst[1]), .cfg_src_mac(src[1]),
    .cfg_ethertype(et[1]), .enable(en[1]), .buf_data(bdata[1]), .buf_empty(bempty[1]),
    .buf_count(bcount[1]), .buf_pop(pop[1]), .M_AXIS_tdata(td[1]), .M_AXIS_tkeep(tk[1]),
    .M_AXIS_tvalid(tv[1]), .M_AXIS_tlast(tl[1]), .M_AXIS_tready(tr[1]), .busy(bsy[1]),
    .frames_sent(fs[1]), .underrun_stalls(us[1])
  );

  // ---------------- bench state ----------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [63:0] fifo [2][$];
  bit          rst_req  [2];
  bit          en_req   [2];
  int unsigned rdy_pct  [2];
  bit          rdy_tog  [2];
  bit          cfg_churn;

  int unsigned idx      [2];
  logic [47:0] s_src    [2];
  logic [15:0] s_et     [2];
  logic [15:0] m_frames [2];
  logic [15:0] m_stalls [2];
  bit          hold_v   [2];
  logic [63:0] hold_d   [2];
  int unsigned hs_cnt   [2];
  int unsigned pop_cnt  [2];
  int unsigned stepn = 0;
  int unsigned hdr_step [2];
  int unsigned tl_step  [2];
  bit          gap_arm  [2];
  int          gap_seen [2];

  function automatic string nm(input int i);
    return (i == 0) ? "A" : "B";
  endfunction

  function automatic int unsigned pw(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  // Frame length is the larger of headers+payload and the minimum frame length.
  function automatic int unsigned total_beats(input int i);
    int unsigned raw;
    raw = 2 + pw(i);
    return (raw < 8) ? 8 : raw;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare one instance against the model for the cycle in progress, then advance the model.
  task automatic evaluate(input int i);
    bit          inpay;
    logic [63:0] exp_d;
    if (arst[i]) begin
      check({nm(i), ".pop_in_reset"}, pop[i], 1'b0);
      idx[i] = 0; m_frames[i] = '0; m_stalls[i] = '0; hold_v[i] = 0; gap_arm[i] = 0;
      return;
    end
    inpay = (idx[i] >= 2) && (idx[i] < 2 + pw(i));
    check({nm(i), ".frames_sent"}, fs[i], m_frames[i]);
    check({nm(i), ".underrun_stalls"}, us[i], m_stalls[i]);
    check({nm(i), ".tkeep"}, tk[i], 8'hFF);
    check({nm(i), ".buf_pop"}, pop[i], inpay && !bempty[i] && tr[i]);
    if (idx[i] >= 1) begin
      check({nm(i), ".tvalid_mid"}, tv[i], inpay ? !bempty[i] : 1'b1);
      check({nm(i), ".busy_mid"}, bsy[i], 1'b1);
    end
    if (hold_v[i]) begin
      check({nm(i), ".hold_valid"}, tv[i], 1'b1);
      check({nm(i), ".hold_data"}, td[i], hold_d[i]);
    end
    if (gap_arm[i] && tv[i] && idx[i] == 0) begin
      gap_seen[i] = int'(stepn - tl_step[i]) - 1;
      gap_arm[i]  = 0;
    end
    if (tv[i] && tr[i]) begin
      hs_cnt[i]++;
      if (idx[i] == 0) begin
        s_src[i] = src[i]; s_et[i] = et[i];
        exp_d = {dst[i], src[i][47:32]};
        hdr_step[i] = stepn;
      end else if (idx[i] == 1) begin
        exp_d = {s_src[i][31:0], s_et[i], 16'h0000};
      end else if (inpay) begin
        exp_d = (fifo[i].size() > 0) ? fifo[i][0] : 64'h0;
      end else begin
        exp_d = 64'h0;
      end
      check({nm(i), ".tdata"}, td[i], exp_d);
      check({nm(i), ".tlast"}, tl[i], idx[i] == total_beats(i) - 1);
      if (idx[i] == total_beats(i) - 1) begin
        idx[i] = 0; m_frames[i] = m_frames[i] + 16'd1;
        tl_step[i] = stepn; gap_arm[i] = 1;
      end else begin
        idx[i]++;
      end
    end
    if (inpay && bempty[i] && m_stalls[i] != 16'hFFFF) m_stalls[i] = m_stalls[i] + 16'd1;
    hold_v[i] = tv[i] && !tr[i];
    hold_d[i] = td[i];
    if (pop[i] && fifo[i].size() > 0) begin
      void'(fifo[i].pop_front());
      pop_cnt[i]++;
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    stepn++;
    for (int i = 0; i < 2; i++) begin
      arst[i] = rst_req[i];
      en[i]   = en_req[i];
      tr[i]   = rdy_tog[i] ? stepn[0] : ($urandom_range(99) < rdy_pct[i]);
      if (cfg_churn && idx[i] >= 1 && $urandom_range(3) == 0) begin
        dst[i] = {$urandom, $urandom};
        src[i] = {$urandom, $urandom};
        et[i]  = $urandom;
      end
      bempty[i] = (fifo[i].size() == 0);
      bdata[i]  = bempty[i] ? {$urandom, $urandom} : fifo[i][0];
      bcount[i] = CW'(fifo[i].size());
    end
    #1;
    for (int i = 0; i < 2; i++) evaluate(i);
  endtask

  // Run until n more frames complete (bounded), then confirm the DUT count one cycle later.
  task automatic run_frames(input int i, input int unsigned n, input int unsigned budget);
    logic [15:0] target;
    target = m_frames[i] + 16'(n);
    for (int unsigned k = 0; k < budget && m_frames[i] != target; k++) step();
    step();
    check({nm(i), ".frames_done"}, fs[i], target);
  endtask

  task automatic push_words(input int i, input int unsigned n, input logic [63:0] base);
    for (int unsigned k = 0; k < n; k++) fifo[i].push_back(base + 64'(k) * 64'h11);
  endtask

  initial begin
    int unsigned hs0, pp0;
    logic [15:0] st0;
    for (int i = 0; i < 2; i++) begin
      arst[i] = 1'b1; rst_req[i] = 1; en_req[i] = 0; rdy_pct[i] = 100; rdy_tog[i] = 0;
      en[i] = 1'b0; tr[i] = 1'b1; bempty[i] = 1'b1; bdata[i] = '0; bcount[i] = '0;
      dst[i] = {$urandom, $urandom}; src[i] = {$urandom, $urandom}; et[i] = $urandom;
      idx[i] = 0; m_frames[i] = '0; m_stalls[i] = '0; hold_v[i] = 0; hold_d[i] = '0;
      hs_cnt[i] = 0; pop_cnt[i] = 0; gap_arm[i] = 0; gap_seen[i] = -1;
      hdr_step[i] = 0; tl_step[i] = 0; s_src[i] = '0; s_et[i] = '0;
    end
    cfg_churn = 0;
    step(); step();
    rst_req[0] = 0; rst_req[1] = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      check({nm(i), ".rst_tvalid"}, tv[i], 1'b0);
      check({nm(i), ".rst_tlast"}, tl[i], 1'b0);
      check({nm(i), ".rst_tdata"}, td[i], 64'h0);
      check({nm(i), ".rst_busy"}, bsy[i], 1'b0);
      check({nm(i), ".rst_frames"}, fs[i], 16'h0);
      check({nm(i), ".rst_stalls"}, us[i], 16'h0);
    end

    // Default frame, preloaded 0x11..0x88, tready held high.
    push_words(0, 8, 64'h11);
    hs0 = hs_cnt[0]; pp0 = pop_cnt[0];
    en_req[0] = 1;
    run_frames(0, 1, 60);
    en_req[0] = 0;
    check("A.default_beats", hs_cnt[0] - hs0, 10);
    check("A.default_pops", pop_cnt[0] - pp0, 8);
    check("A.zero_bubble_span", tl_step[0] - hdr_step[0] + 1, 10);
    repeat (6) step();

    // Short payload with zero padding.
    push_words(1, 2, 64'hA0);
    hs0 = hs_cnt[1]; pp0 = pop_cnt[1];
    en_req[1] = 1;
    run_frames(1, 1, 60);
    check("B.pad_beats", hs_cnt[1] - hs0, 8);
    check("B.pad_pops", pop_cnt[1] - pp0, 2);
    gap_arm[1] = 0; gap_seen[1] = -1;
    push_words(1, 4, 64'hB0);
    run_frames(1, 2, 80);
    check("B.gap_idle", gap_seen[1], 1);
    en_req[1] = 0;
    repeat (4) step();

    // tready toggling every cycle.
    push_words(0, 8, 64'h1000);
    hs0 = hs_cnt[0]; pp0 = pop_cnt[0];
    rdy_tog[0] = 1; en_req[0] = 1;
    run_frames(0, 1, 100);
    en_req[0] = 0; rdy_tog[0] = 0;
    check("A.toggle_beats", hs_cnt[0] - hs0, 10);
    check("A.toggle_pops", pop_cnt[0] - pp0, 8);
    repeat (6) step();

    // Underrun: 3 words, 5 empty cycles, then 5 words.
    st0 = m_stalls[0];
    push_words(0, 3, 64'h2000);
    en_req[0] = 1;
    for (int k = 0; k < 40 && !(idx[0] == 5 && fifo[0].size() == 0); k++) step();
    en_req[0] = 0;
    repeat (5) step();
    push_words(0, 5, 64'h3000);
    run_frames(0, 1, 60);
    check("A.underrun_stalls", us[0], st0 + 16'd5);
    repeat (6) step();

    // Reset after the 4th payload beat of a frame.
    push_words(0, 8, 64'h4000);
    en_req[0] = 1;
    for (int k = 0; k < 40 && idx[0] != 6; k++) step();
    rst_req[0] = 1;
    step();
    rst_req[0] = 0;
    step();
    check("A.post_rst_tvalid", tv[0], 1'b0);
    check("A.post_rst_busy", bsy[0], 1'b0);
    check("A.post_rst_frames", fs[0], 16'h0);
    check("A.post_rst_stalls", us[0], 16'h0);
    check("A.post_rst_left", fifo[0].size(), 4);
    push_words(0, 4, 64'h5000);
    run_frames(0, 1, 60);
    en_req[0] = 0;
    repeat (6) step();

    // enable low with 16 words buffered, then two back-to-back frames.
    push_words(0, 16, 64'h6000);
    pp0 = pop_cnt[0];
    repeat (10) step();
    check("A.disabled_busy", bsy[0], 1'b0);
    check("A.disabled_pops", pop_cnt[0] - pp0, 0);
    gap_arm[0] = 0; gap_seen[0] = -1;
    en_req[0] = 1;
    run_frames(0, 2, 80);
    check("A.gap_idle", gap_seen[0], 4);
    check("A.b2b_left", fifo[0].size(), 0);

    // Randomized traffic on both instances with header churn mid-frame.
    cfg_churn = 1;
    rdy_pct[0] = 70; rdy_pct[1] = 60;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (fifo[i].size() < 60 && $urandom_range(99) < 45)
          fifo[i].push_back({$urandom, $urandom});
        if ($urandom_range(99) < 4) en_req[i] = !en_req[i];
      end
      step();
    end
    en_req[0] = 0; en_req[1] = 0;
    rdy_pct[0] = 100; rdy_pct[1] = 100;
    repeat (300) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
